// File: rtl/dct1d_stream.sv
// rtl/dct1d_stream.sv - streaming 8-point 1-D DCT-II with valid/ready handshakes
//
// Purpose: takes blocks of 8 samples x[0..7] and emits 8 signed coefficients
// y[0..7] per block. Each accepted sample is multiplied by one column of a
// constant cosine ROM and added into 8 parallel accumulators. A completed
// block is rounded, saturated and parked in an output bank that drains one
// coefficient per handshake. The next block accumulates while the bank drains.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     input sample valid
//   in_ready     block can accept a sample
//   in_data      sample x[n], IN_W bits
//   level_shift  sampled with x[0]; subtract 2^(IN_W-1) from the whole block
//   out_valid    out_data holds a coefficient
//   out_ready    sink accepts the coefficient
//   out_data     coefficient y[k], signed OUT_W bits
//   out_idx      coefficient index k
//   out_last     high with out_valid when out_idx == 7
module dct1d_stream #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 12,
  parameter int FRAC      = 12,
  parameter bit SIGNED_IN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             level_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [2:0]       out_idx,
  output logic             out_last
);

  localparam int XW    = IN_W + 1;         // signed operand width
  localparam int CW    = FRAC + 1;         // signed coefficient width (|C| < 2^(FRAC-1))
  localparam int ACC_W = IN_W + FRAC + 5;  // XW + CW + 3 guard bits for 8 terms

  // Basis magnitudes scaled by 2^30, far beyond FRAC so that the final
  // rounding to FRAC bits is exact. Index 0 is sqrt(1/8); index j>0 is
  // cos(j*pi/16)/2.
  function automatic longint base_mag(input int j);
    case (j)
      0:       base_mag = 64'sd379625062;
      1:       base_mag = 64'sd526555088;
      2:       base_mag = 64'sd496004047;
      3:       base_mag = 64'sd446391849;
      4:       base_mag = 64'sd379625062;
      5:       base_mag = 64'sd298269498;
      6:       base_mag = 64'sd205451603;
      7:       base_mag = 64'sd104738319;
      default: base_mag = 64'sd0;
    endcase
  endfunction

  // C[k][n]: fold the angle (2n+1)k*pi/16 into 0..pi/2 and track the sign,
  // then round half away from zero on the magnitude.
  function automatic logic signed [CW-1:0] rom_coef(input int k, input int n);
    int     a;
    logic   neg;
    longint scaled;
    a   = 0;
    neg = 1'b0;
    if (k != 0) begin
      a = ((2 * n + 1) * k) % 32;
      if (a > 16) a = 32 - a;
      neg = (a > 8);
      if (neg) a = 16 - a;
    end
    scaled = (base_mag(a) * (64'sd1 <<< FRAC) + (64'sd1 <<< 29)) >>> 30;
    rom_coef = neg ? CW'(-scaled) : CW'(scaled);
  endfunction

  function automatic logic [64*CW-1:0] build_rom();
    logic [64*CW-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 8; n++) begin
        r[(k * 8 + n) * CW +: CW] = rom_coef(k, n);
      end
    end
    return r;
  endfunction

  localparam logic [64*CW-1:0] ROM = build_rom();

  localparam logic signed [XW-1:0]  HALF    = {2'b01, {(IN_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] ONE_W   = (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0] RND     = ONE_W <<< (FRAC - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ONE_W <<< (OUT_W - 1)) - ONE_W;
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - ONE_W;

  typedef enum logic {S_ACC, S_FULL} state_e;

  state_e                  state_q;
  logic [2:0]              cnt_q;
  logic                    ls_q;
  logic signed [ACC_W-1:0] acc_q [8];
  logic [OUT_W-1:0]        bank_q [8];
  logic                    bank_full_q;
  logic [2:0]              oidx_q;

  logic                    in_fire;
  logic                    out_fire;
  logic                    bank_free;
  logic                    ls_eff;
  logic signed [XW-1:0]    x_op;
  logic signed [CW-1:0]    coef [8];
  logic signed [ACC_W-1:0] prod [8];
  logic signed [ACC_W:0]   rnd [8];
  logic signed [ACC_W:0]   shr [8];
  logic [OUT_W-1:0]        y_sat [8];

  // Outputs are gated by rst so they read idle during the reset cycle itself.
  assign in_ready  = !rst && (state_q == S_ACC);
  assign out_valid = !rst && bank_full_q;
  assign out_data  = rst ? '0 : bank_q[oidx_q];
  assign out_idx   = rst ? 3'd0 : oidx_q;
  assign out_last  = out_valid && (oidx_q == 3'd7);

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  // The final handshake frees the bank on the same edge a waiting block loads.
  assign bank_free = !bank_full_q || (out_fire && (oidx_q == 3'd7));

  always_comb begin
    // x[0] carries the block's level_shift itself; later samples use the copy.
    ls_eff = (cnt_q == 3'd0) ? level_shift : ls_q;
    if (SIGNED_IN) begin
      x_op = XW'($signed(in_data));
    end else if (ls_eff) begin
      x_op = $signed({1'b0, in_data}) - HALF;
    end else begin
      x_op = $signed({1'b0, in_data});
    end
    for (int k = 0; k < 8; k++) begin
      coef[k]  = $signed(ROM[(k * 8 + int'(cnt_q)) * CW +: CW]);
      prod[k]  = ACC_W'(x_op) * ACC_W'(coef[k]);
      rnd[k]   = (ACC_W+1)'(acc_q[k]) + RND;
      shr[k]   = rnd[k] >>> FRAC;
      if (shr[k] > SAT_MAX) begin
        y_sat[k] = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (shr[k] < SAT_MIN) begin
        y_sat[k] = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        y_sat[k] = OUT_W'(shr[k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACC;
      cnt_q       <= 3'd0;
      ls_q        <= 1'b0;
      bank_full_q <= 1'b0;
      oidx_q      <= 3'd0;
      for (int k = 0; k < 8; k++) begin
        acc_q[k]  <= '0;
        bank_q[k] <= '0;
      end
    end else begin
      if (out_fire) begin
        oidx_q <= oidx_q + 3'd1;
        if (oidx_q == 3'd7) bank_full_q <= 1'b0;
      end
      case (state_q)
        S_ACC: begin
          if (in_fire) begin
            for (int k = 0; k < 8; k++) begin
              acc_q[k] <= (cnt_q == 3'd0) ? prod[k] : acc_q[k] + prod[k];
            end
            if (cnt_q == 3'd0) ls_q <= level_shift;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= S_FULL;
          end
        end
        S_FULL: begin
          if (bank_free) begin
            for (int k = 0; k < 8; k++) begin
              bank_q[k] <= y_sat[k];
            end
            bank_full_q <= 1'b1;
            oidx_q      <= 3'd0;
            state_q     <= S_ACC;
          end
        end
        default: state_q <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_dct1d_stream.sv
// tb/tb_dct1d_stream.sv - self-checking bench for dct1d_stream
module tb_dct1d_stream;

  localparam int IN_W  = 8;
  localparam int OUT_W = 12;
  localparam int FRAC  = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid, in_ready, level_shift;
  logic [IN_W-1:0]  in_data;
  logic             out_valid, out_ready, out_last;
  logic [OUT_W-1:0] out_data;
  logic [2:0]       out_idx;

  logic             in_valid9, in_ready9, level_shift9;
  logic [IN_W-1:0]  in_data9;
  logic             out_valid9, out_ready9, out_last9;
  logic [8:0]       out_data9;
  logic [2:0]       out_idx9;

  dct1d_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC(FRAC), .SIGNED_IN(1'b0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .level_shift(level_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
  );

  dct1d_stream #(.IN_W(IN_W), .OUT_W(9), .FRAC(FRAC), .SIGNED_IN(1'b0)) dut9 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid9), .in_ready(in_ready9), .in_data(in_data9), .level_shift(level_shift9),
    .out_valid(out_valid9), .out_ready(out_ready9), .out_data(out_data9),
    .out_idx(out_idx9), .out_last(out_last9)
  );

  typedef struct {
    longint data;
    int     idx;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   cm [8][8];
  exp_t exp_q [$];
  int   rdy_mode = 0;  // 0: out_ready low, 1: high, 2: random
  bit   gap_mode = 1'b0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference DCT straight from the math: real cosines, rounded coefficients,
  // integer dot product, round-to-nearest shift, clamp.
  task automatic build_model();
    real pi, ck, v;
    pi = 3.14159265358979323846;
    for (int k = 0; k < 8; k++) begin
      ck = (k == 0) ? $sqrt(0.125) : 0.5;
      for (int n = 0; n < 8; n++) begin
        v = (2.0 ** FRAC) * ck * $cos(real'((2 * n + 1) * k) * pi / 16.0);
        cm[k][n] = (v >= 0.0) ? $rtoi($floor(v + 0.5)) : -$rtoi($floor(-v + 0.5));
      end
    end
  endtask

  function automatic longint model_y(input int k, input int xs[8], input bit ls, input int ow);
    longint acc, y, hi, lo;
    acc = 0;
    for (int n = 0; n < 8; n++) begin
      acc += longint'(cm[k][n]) * longint'(ls ? xs[n] - 128 : xs[n]);
    end
    y  = (acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
    hi = (64'sd1 <<< (ow - 1)) - 1;
    lo = -hi - 1;
    if (y > hi) y = hi;
    if (y < lo) y = lo;
    return y;
  endfunction

  task automatic push_model(input int xs[8], input bit ls);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.data = model_y(k, xs, ls, OUT_W);
      e.idx  = k;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_const(input longint y0);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.data = (k == 0) ? y0 : 0;
      e.idx  = k;
      exp_q.push_back(e);
    end
  endtask

  // Starts and ends on a falling edge; the sample is taken on the rising edge between.
  task automatic send_sample(input int d, input bit ls);
    int n;
    n = 0;
    if (gap_mode && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    in_valid    = 1'b1;
    in_data     = IN_W'(d);
    level_shift = ls;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check_eq("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int xs[8], input bit ls);
    for (int n = 0; n < 8; n++) send_sample(xs[n], ls);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic set_rdy(input int m);
    @(posedge clk);
    rdy_mode = m;
    @(negedge clk);
  endtask

  // Sink: chooses out_ready each cycle and scores every handshake in order.
  initial begin
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_data", $signed(out_data), e.data);
          check_eq("out_idx", out_idx, e.idx);
          check_eq("out_last", out_last, e.idx == 7);
        end
      end
    end
  end

  initial begin
    int     xs[8];
    int     n;
    int     cnt;
    longint y0a;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; level_shift = 1'b0;
    in_valid9 = 1'b0; in_data9 = '0; level_shift9 = 1'b0; out_ready9 = 1'b1;
    build_model();

    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_idx", out_idx, 0);
    check_eq("rst_out_last", out_last, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("in_ready_after_rst", in_ready, 1);

    // DC block, latency from x[7] to first coefficient
    set_rdy(1);
    push_const(721);
    for (int i = 0; i < 8; i++) send_sample(255, 1'b0);
    check_eq("lat_pre", out_valid, 0);
    @(negedge clk);
    check_eq("lat_valid", out_valid, 1);
    check_eq("lat_idx", out_idx, 0);
    wait_drain();
    check_eq("idle_after_drain", out_valid, 0);

    // Level shift extremes
    push_const(359);
    for (int i = 0; i < 8; i++) send_sample(255, 1'b1);
    wait_drain();
    push_const(-362);
    for (int i = 0; i < 8; i++) send_sample(0, 1'b1);
    wait_drain();

    // Saturation on a 9-bit output instance
    n = 0; cnt = 0;
    in_valid9 = 1'b1; in_data9 = 8'd255;
    while (cnt < 8 && n < 100) begin
      if (in_ready9) cnt++;
      @(negedge clk);
      n++;
    end
    in_valid9 = 1'b0;
    n = 0;
    while (!out_valid9 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("sat9_y0", $signed(out_data9), 255);
    check_eq("sat9_idx0", out_idx9, 0);
    check_eq("sat9_last0", out_last9, 0);
    @(negedge clk);
    check_eq("sat9_y1", $signed(out_data9), 0);

    // Stalled sink while two blocks stream in, then back-to-back drain
    set_rdy(0);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) xs[i] = int'($urandom_range(0, 255));
      push_model(xs, 1'b0);
      send_block(xs, 1'b0);
    end
    y0a = exp_q[0].data;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("stall_in_ready", in_ready, 0);
      check_eq("stall_out_valid", out_valid, 1);
      check_eq("stall_out_data", $signed(out_data), y0a);
      check_eq("stall_out_idx", out_idx, 0);
      check_eq("stall_out_last", out_last, 0);
    end
    @(posedge clk);
    rdy_mode = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_eq("b2b_valid", out_valid, 1);
    end
    @(negedge clk);
    check_eq("b2b_done_valid", out_valid, 0);
    check_eq("b2b_queue", exp_q.size(), 0);

    // Reset with a full bank and a partial block pending
    set_rdy(0);
    for (int i = 0; i < 8; i++) xs[i] = int'($urandom_range(0, 255));
    push_model(xs, 1'b1);
    send_block(xs, 1'b1);
    for (int i = 0; i < 3; i++) send_sample(int'($urandom_range(0, 255)), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    set_rdy(1);
    check_eq("postrst_bank_empty", out_valid, 0);
    check_eq("postrst_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) xs[i] = int'($urandom_range(0, 255));
    push_model(xs, 1'b0);
    send_block(xs, 1'b0);
    wait_drain();

    // Random blocks with random gaps on both sides
    gap_mode = 1'b1;
    set_rdy(2);
    for (int b = 0; b < 1000; b++) begin
      bit ls;
      ls = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        case (b % 10)
          0:       xs[i] = 255;
          1:       xs[i] = 0;
          default: xs[i] = int'($urandom_range(0, 255));
        endcase
      end
      push_model(xs, ls);
      send_block(xs, ls);
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
